// File: rtl/spi_frame_arbiter.sv
// -----------------------------------------------------------------------------
// spi_frame_arbiter
//
// Shares one DW-bit, LSB-first SPI master between NREQ requesters using
// round-robin arbitration. The winner's word is captured at launch, presented
// to the master with a held spi_newd strobe, and the master's chip-select is
// tracked to find frame start and frame end. The owner gets a one-cycle done
// pulse when its frame has completed.
//
// Optional feature (macro SPI_FRAME_ARB_TIMEOUT_EN):
//   When defined, a launch that the master does not pick up within TIMEOUT
//   cycles is abandoned. err[owner] pulses and the pointer moves on. When the
//   macro is undefined, LAUNCH waits indefinitely and err is tied to 0.
//
// Ports:
//   clk       single clock, shared with the SPI master
//   rst       synchronous, active-high reset
//   req       per-requester request level, held until the matching done
//   din       packed request words, requester i at [i*DW +: DW]
//   grant     one-hot owner, from launch until the done/err edge
//   done      one-cycle pulse to the owner at frame end
//   err       one-cycle pulse to the owner on launch timeout
//   busy      high whenever the FSM is not idle
//   spi_newd  to master newd, held until chip-select falls
//   spi_din   to master din, stable for the whole frame
//   spi_cs    master chip-select, active low, idle high
// -----------------------------------------------------------------------------
module spi_frame_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 12,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    output logic               busy,
    output logic               spi_newd,
    output logic [DW-1:0]      spi_din,
    input  logic               spi_cs
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        XFER,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   ptr_inc;
    logic [NREQ-1:0] grant_nxt, done_nxt;
    logic            newd_nxt;
    logic [DW-1:0]   din_nxt;
    logic            found;
    logic [IW-1:0]   winner;

`ifdef SPI_FRAME_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NREQ-1:0] err_nxt;
`else
    assign err = '0;
`endif

    assign busy = (state != IDLE);

    // Pointer moves to the requester after the current owner, wrapping.
    assign ptr_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

    // Round-robin search: start at ptr, wrap modulo NREQ, first hit wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found  = 1'b1;
                winner = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // NOTE: every next-state value gets a default first, so no path through
    // the case statement leaves a variable unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        grant_nxt = grant;
        done_nxt  = '0;
        newd_nxt  = spi_newd;
        din_nxt   = spi_din;
`ifdef SPI_FRAME_ARB_TIMEOUT_EN
        err_nxt   = '0;
        cnt_nxt   = cnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt = winner;
                    grant_nxt = NREQ'(1) << winner;
                    din_nxt   = din[int'(winner)*DW +: DW];
                    newd_nxt  = 1'b1;
                    state_nxt = LAUNCH;
`ifdef SPI_FRAME_ARB_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            LAUNCH: begin
                // The master has started the frame once chip-select drops.
                if (!spi_cs) begin
                    newd_nxt  = 1'b0;
                    state_nxt = XFER;
                end
`ifdef SPI_FRAME_ARB_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_nxt   = grant;
                    grant_nxt = '0;
                    newd_nxt  = 1'b0;
                    ptr_nxt   = ptr_inc;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
`endif
            end
            XFER: begin
                if (spi_cs) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_nxt  = grant;
                grant_nxt = '0;
                ptr_nxt   = ptr_inc;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            grant    <= '0;
            done     <= '0;
            spi_newd <= 1'b0;
            spi_din  <= '0;
`ifdef SPI_FRAME_ARB_TIMEOUT_EN
            err      <= '0;
            cnt      <= '0;
`endif
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            grant    <= grant_nxt;
            done     <= done_nxt;
            spi_newd <= newd_nxt;
            spi_din  <= din_nxt;
`ifdef SPI_FRAME_ARB_TIMEOUT_EN
            err      <= err_nxt;
            cnt      <= cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for spi_frame_arbiter.
// A behavioural SPI master answers spi_newd by dropping chip-select, shifting
// DW bits LSB first and raising chip-select again. Stimulus pushes the expected
// (grant, word) of each launch into a queue; the monitor pops on every launch
// and closes the entry on done or err.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_frame_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 12;
    localparam int TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] din = '0;
    logic               spi_cs = 1'b1;
    logic [NREQ-1:0]    grant, done, err;
    logic               busy, spi_newd;
    logic [DW-1:0]      spi_din;

    always #5 clk = ~clk;

    spi_frame_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din      (din),
        .grant    (grant),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .spi_newd (spi_newd),
        .spi_din  (spi_din),
        .spi_cs   (spi_cs)
    );

    typedef struct packed {
        logic [NREQ-1:0] g;
        logic [DW-1:0]   w;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    int            cyc    = 0;
    bit            master_en = 1'b1;
    logic [DW-1:0] mosi_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic miss(input string name, input int budget);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: no event within %0d cycles (t=%0t)", name, budget, $time);
    endtask

    // Wait for a done (use_err=0) or err (use_err=1) pulse overlapping mask.
    task automatic wait_pulse(input string name, input logic [NREQ-1:0] mask,
                              input bit use_err, input int budget);
        bit hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk);
            if (((use_err ? err : done) & mask) != '0) hit = 1'b1;
        end
        if (!hit) miss(name, budget);
    endtask

    task automatic wait_cs_low(input string name, input int budget);
        bit hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk);
            if (!spi_cs) hit = 1'b1;
        end
        if (!hit) miss(name, budget);
    endtask

    task automatic set_word(input int idx, input logic [DW-1:0] w);
        din[idx*DW +: DW] = w;
    endtask

    // Behavioural SPI master: samples newd, starts a frame a few cycles later,
    // reads one bit of spi_din per bit period, LSB first. A reset of the
    // arbiter (busy dropping) aborts the frame.
    initial begin : master
        bit aborted;
        forever begin
            @(negedge clk);
            if (!rst && master_en && spi_newd) begin
                aborted   = 1'b0;
                mosi_word = 'x;
                repeat (3) @(negedge clk);
                spi_cs = 1'b0;
                for (int i = 0; i < DW && !aborted; i++) begin
                    repeat (2) begin
                        @(negedge clk);
                        if (!busy) aborted = 1'b1;
                    end
                    if (!aborted) mosi_word[i] = spi_din[i];
                end
                spi_cs = 1'b1;
            end
        end
    end

    // Monitor: pops an expectation on each launch, closes it on done/err.
    initial begin : monitor
        exp_t            cur;
        bit              cur_v = 1'b0;
        int              launch_cyc = 0;
        logic [NREQ-1:0] prev_done = '0;
        logic            prev_newd = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                cur_v     = 1'b0;
                prev_done = '0;
                prev_newd = 1'b0;
            end else begin
                if (prev_done != '0) check("done_width", done, '0);
                if (spi_newd && !prev_newd) begin
                    launch_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        miss("unexpected_launch", 0);
                    end else begin
                        cur   = exp_q.pop_front();
                        cur_v = 1'b1;
                        check("launch_grant", grant, cur.g);
                        check("launch_spi_din", spi_din, cur.w);
                    end
                end
                if (done != '0) begin
                    if (!cur_v) begin
                        check("unexpected_done", done, '0);
                    end else begin
                        check("done_owner", done, cur.g);
                        check("mosi_word", mosi_word, cur.w);
                        cur_v = 1'b0;
                    end
                end
                if (err != '0) begin
                    if (!cur_v) begin
                        check("unexpected_err", err, '0);
                    end else begin
                        check("err_owner", err, cur.g);
                        check("err_latency", cyc - launch_cyc, TIMEOUT);
                        cur_v = 1'b0;
                    end
                end
                prev_done = done;
                prev_newd = spi_newd;
            end
        end
    end

    initial begin : watchdog
        repeat (30000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: bench did not finish within 30000 cycles");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : stim
        bit seen_err;

        // Reset for two cycles, then check every output's reset value.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_grant", grant, '0);
        check("rst_done", done, '0);
        check("rst_err", err, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_newd", spi_newd, 1'b0);
        check("rst_spi_din", spi_din, '0);
        rst = 1'b0;

        // Single request, word 0xA5C (MOSI LSB first 0,0,1,1,1,0,1,0,0,1,0,1).
        set_word(0, 12'hA5C);
        exp_q.push_back('{g: 4'b0001, w: 12'hA5C});
        req = 4'b0001;
        @(negedge clk);
        check("single_latency_grant", grant, 4'b0001);
        check("single_latency_newd", spi_newd, 1'b1);
        wait_pulse("single_done", 4'b0001, 1'b0, 200);
        req = '0;

        // Reset to bring the pointer back to 0, then full contention.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_word(0, 12'h123);
        set_word(1, 12'h456);
        set_word(2, 12'h789);
        set_word(3, 12'hABC);
        exp_q.push_back('{g: 4'b0001, w: 12'h123});
        exp_q.push_back('{g: 4'b0010, w: 12'h456});
        exp_q.push_back('{g: 4'b0100, w: 12'h789});
        exp_q.push_back('{g: 4'b1000, w: 12'hABC});
        exp_q.push_back('{g: 4'b0001, w: 12'h123});
        req = 4'b1111;
        wait_pulse("rr_done0", 4'b0001, 1'b0, 200);
        wait_pulse("rr_done1", 4'b0010, 1'b0, 200);
        wait_pulse("rr_done2", 4'b0100, 1'b0, 200);
        wait_pulse("rr_done3", 4'b1000, 1'b0, 200);
        wait_pulse("rr_done4", 4'b0001, 1'b0, 200);
        req = '0;

        // Pointer now 1: requester 2 alone; change its word and drop req mid-frame.
        set_word(2, 12'h3C7);
        exp_q.push_back('{g: 4'b0100, w: 12'h3C7});
        req = 4'b0100;
        wait_cs_low("chg_cs_low", 50);
        repeat (4) @(negedge clk);
        set_word(2, 12'hFFF);
        req = '0;
        wait_pulse("chg_done", 4'b0100, 1'b0, 200);

        // Pointer now 3: launch requester 1, reset it in XFER.
        set_word(1, 12'h5A5);
        set_word(3, 12'h6B6);
        exp_q.push_back('{g: 4'b0010, w: 12'h5A5});
        req = 4'b0010;
        wait_cs_low("rst_mid_cs_low", 50);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_grant", grant, '0);
        check("rst_mid_newd", spi_newd, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, '0);
        rst = 1'b0;
        // Pointer back at 0: 1010 must go to requester 1 before requester 3.
        exp_q.push_back('{g: 4'b0010, w: 12'h5A5});
        req = 4'b1010;
        wait_pulse("post_rst_done1", 4'b0010, 1'b0, 200);
        exp_q.push_back('{g: 4'b1000, w: 12'h6B6});
        req = 4'b1000;
        wait_pulse("post_rst_done3", 4'b1000, 1'b0, 200);
        req = '0;

        // Pointer now 0: stubbed master never drops chip-select.
        master_en = 1'b0;
        set_word(2, 12'h2D2);
        set_word(3, 12'h7E7);
        exp_q.push_back('{g: 4'b0100, w: 12'h2D2});
        req = 4'b0100;
`ifdef SPI_FRAME_ARB_TIMEOUT_EN
        wait_pulse("timeout_err", 4'b0100, 1'b1, 200);
        // Pointer moves to 3, so 1001 is granted to requester 3 first.
        master_en = 1'b1;
        exp_q.push_back('{g: 4'b1000, w: 12'h7E7});
        req = 4'b1001;
        wait_pulse("after_to_done3", 4'b1000, 1'b0, 200);
        exp_q.push_back('{g: 4'b0001, w: 12'h123});
        req = 4'b0001;
        wait_pulse("after_to_done0", 4'b0001, 1'b0, 200);
        req = '0;
`else
        seen_err = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (err != '0) seen_err = 1'b1;
        end
        check("no_timeout_err", seen_err, 1'b0);
        check("no_timeout_busy", busy, 1'b1);
        check("no_timeout_newd", spi_newd, 1'b1);
        check("no_timeout_grant", grant, 4'b0100);
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        master_en = 1'b1;
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_arbiter.md
# spi_frame_arbiter

Round-robin arbiter that shares one 12-bit, LSB-first SPI master between NREQ requesters. It latches the winning requester's 12-bit word and launches it on the master with a held `newd` strobe. It then tracks the master's chip-select to detect frame start and frame end, and returns a one-cycle `done` pulse to the owner. The block sits between the on-chip clients and the SPI master, in the master's `clk` domain.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 12, frame width; must equal the master's data width
- TIMEOUT, 64, `clk` cycles allowed between `spi_newd` assertion and `spi_cs` falling (only with the timeout macro)
- clk  input  1  single clock, shared with the SPI master
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request level; held high until the matching `done`
- din  input  NREQ*DW  packed data, requester i at bits [i*DW +: DW]
- grant  output  NREQ  one-hot owner, held from launch through done; reset 0
- done  output  NREQ  one-cycle pulse to the owner at frame end; reset 0
- err  output  NREQ  one-cycle pulse to the owner on launch timeout; reset 0
- busy  output  1  high whenever state ≠ IDLE; reset 0
- spi_newd  output  1  to master `newd`; reset 0
- spi_din  output  DW  to master `din`, stable while `spi_newd`=1; reset 0
- spi_cs  input  1  master chip-select, active low, idle high

## Operation
- States: IDLE, LAUNCH, XFER, DONE.
- **IDLE**
  - If any `req` bit is high, pick the winner by round-robin: search starts at index `ptr`, wraps modulo NREQ, lowest index searched first.
  - Latch `din` slice into `spi_din`, set `grant` one-hot, set `spi_newd`=1, go to LAUNCH.
- **LAUNCH**
  - Hold `spi_newd`=1 and `spi_din` constant.
  - On `spi_cs`=0: clear `spi_newd`, go to XFER.
- **XFER**
  - Wait for `spi_cs`=1 (frame end); then go to DONE.
- **DONE**
  - Pulse `done[owner]` for one cycle, clear `grant`, set `ptr` = owner+1 (wrap to 0 past NREQ-1), return to IDLE.
- **Reset**
  - `ptr`=0, so requester 0 has first priority.
  - `ptr` is updated only in DONE, or on an err exit.
- **Data capture:** `din` is sampled only in the IDLE→LAUNCH cycle. Later changes to `din` have no effect on the frame in flight.
- **Dropped request:** deasserting `req[owner]` during LAUNCH or XFER does not abort. The frame completes and `done` still pulses.
- **Simultaneous requests:** only one grant at a time. Losers stay pending and are served in round-robin order; no requester is starved beyond NREQ-1 frames.
- **`req` high during DONE:** not sampled in that cycle. It is sampled in the next IDLE cycle.
- **Reset mid-frame:** every output returns to its reset value on the next edge and the state goes to IDLE. The master is reset by the same `rst`.

## Timing
- `req` high in IDLE → `grant`, `spi_newd`, `spi_din` valid on the next edge (1-cycle latency).
- `spi_newd` stays high until the first cycle `spi_cs`=0 is seen. This covers the master's divided-clock sampling; the master samples `newd` on its `sclk` rising edge, at most 8 `clk` cycles later.
- `spi_newd` falls one cycle after `spi_cs` falls. It is low before the master's frame-end `sclk` edge.
- `spi_cs` rising → `done` high on the edge after DONE is entered. `done` is high for exactly 1 cycle.
- Back-to-back frames: IDLE lasts 1 cycle minimum between frames.
- Arbitration turnaround from DONE to the next `spi_newd` is 2 cycles.

## Configuration
- Macro: `SPI_FRAME_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in LAUNCH.
  - If `spi_cs` is still 1 after TIMEOUT cycles: pulse `err[owner]` for 1 cycle, drop `spi_newd` and `grant`, set `ptr` = owner+1, return to IDLE.
  - `done` is not pulsed on a timeout.
- **Undefined:**
  - No counter; LAUNCH waits indefinitely.
  - `err` is tied to 0.

## Test plan
- **Single request:** `rst` for 2 cycles, then `req`=0001 with `din[11:0]`=0xA5C.
  - Requires `grant`=0001 and `spi_din`=0xA5C one cycle later, then MOSI bits LSB first (0,0,1,1,1,0,1,0,0,1,0,1).
  - Requires `done`=0001 pulsed once after `spi_cs` returns high.
- **Round-robin under contention:** `req`=1111, all held.
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Each `done` matches the preceding grant; `spi_din` matches each requester's word.
- **Data change and dropped request mid-frame:** change `din` and drop `req[owner]` during XFER.
  - Transmitted frame equals the word captured at launch; `done` still pulses.
- **Reset mid-frame:** assert `rst` during XFER.
  - Next edge: `grant`=0, `spi_newd`=0, `busy`=0, `ptr`=0.
  - `req`=1010 after reset is granted to requester 1 first.
- **Timeout (macro defined):** hold `spi_cs`=1 with a stubbed master, `req`=0100, TIMEOUT=64.
  - `err`=0100 pulses 64 cycles after `spi_newd` rises; `done` stays 0.
  - Next grant goes to requester 3 if it is requesting.
- **Macro undefined, same stimulus:** LAUNCH persists and `err` stays 0 for 1000 cycles.
